// File: rtl/text_buffer_arbiter.sv
// text_buffer_arbiter: owns the single-port text RAM and shares it
// between renderer (highest), clear sequencer and host port.
module text_buffer_arbiter #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  pixel_clock,
  input  logic                  reset,
  input  logic                  render_req,
  input  logic [ADDR_WIDTH-1:0] render_index,
  output logic [7:0]            render_data,
  output logic                  render_valid,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid,
  input  logic                  clear_start,
  input  logic [7:0]            clear_char,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [ADDR_WIDTH:0] CELLS_W =
    (ADDR_WIDTH+1)'(CELLS);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(CELLS - 1);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [7:0]            fill_q;
  logic                  busy_q;
  logic                  done_q;

  logic rrd_q, rrd_d;
  logic rrd_oor_q, rrd_oor_d;
  logic hrd_q, hrd_d;
  logic hrd_oor_q, hrd_oor_d;

  logic render_oor;
  logic host_oor;
  logic clr_wr;

  assign render_oor = {1'b0, render_index} >= CELLS_W;
  assign host_oor   = {1'b0, host_addr} >= CELLS_W;

  assign host_ready = host_valid & ~render_req &
                      (state_q == S_IDLE);
  assign clr_wr     = (state_q == S_CLEAR) & ~render_req;

  // RAM port owner: the three grant terms are mutually exclusive
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    unique case (1'b1)
      render_req: begin
        mem_en   = ~render_oor;
        mem_addr = render_index;
      end
      clr_wr: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = fill_q;
      end
      host_ready: begin
        mem_en    = ~host_oor;
        mem_we    = host_we & ~host_oor;
        mem_addr  = host_addr;
        mem_wdata = (host_we & ~host_oor) ? host_wdata : 8'h00;
      end
      default: ;
    endcase
  end

  assign rrd_d     = render_req;
  assign rrd_oor_d = render_oor;
  assign hrd_d     = host_ready & ~host_we;
  assign hrd_oor_d = host_oor;

  // Remember who issued last cycle's read so the data goes to one client
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      rrd_q     <= 1'b0;
      rrd_oor_q <= 1'b0;
      hrd_q     <= 1'b0;
      hrd_oor_q <= 1'b0;
    end else begin
      rrd_q     <= rrd_d;
      rrd_oor_q <= rrd_oor_d;
      hrd_q     <= hrd_d;
      hrd_oor_q <= hrd_oor_d;
    end
  end

  assign render_valid = rrd_q;
  assign render_data  = (rrd_q & ~rrd_oor_q) ? mem_rdata : 8'h00;
  assign host_rvalid  = hrd_q;
  assign host_rdata   = (hrd_q & ~hrd_oor_q) ? mem_rdata : 8'h00;

  // Clear sequencer: walks every cell, yielding to renderer fetches
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      fill_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (clear_start) begin
            state_q <= S_CLEAR;
            fill_q  <= clear_char;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (!render_req) begin
            if (ptr_q == LAST) begin
              state_q <= S_IDLE;
              ptr_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// tb_text_buffer_arbiter: scoreboard bench with a screen-level
// reference model and a behavioural synchronous RAM.
module tb_text_buffer_arbiter;

  localparam int CELLS = 2400;

  logic        pixel_clock = 1'b0;
  logic        reset = 1'b0;
  logic        render_req = 1'b0;
  logic [11:0] render_index = '0;
  logic [7:0]  render_data;
  logic        render_valid;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        clear_start = 1'b0;
  logic [7:0]  clear_char = '0;
  logic        clear_busy;
  logic        clear_done;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 pixel_clock = ~pixel_clock;

  text_buffer_arbiter dut (
    .pixel_clock  (pixel_clock),
    .reset        (reset),
    .render_req   (render_req),
    .render_index (render_index),
    .render_data  (render_data),
    .render_valid (render_valid),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .clear_start  (clear_start),
    .clear_char   (clear_char),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Behavioural RAM plus per-address write counter
  logic [7:0] ram [4096];
  int         wr_cnt [4096];
  logic       cnt_en = 1'b0;
  logic       cnt_clr = 1'b0;

  always @(posedge pixel_clock) begin
    if (cnt_clr)
      for (int i = 0; i < 4096; i++) wr_cnt[i] <= 0;
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        if (cnt_en && !cnt_clr)
          wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge pixel_clock) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Screen-level reference model
  typedef struct {
    int         due;
    logic [7:0] val;
  } rsp_t;

  logic [7:0] scr [CELLS];
  bit         clr_act = 0;
  int         clr_cnt = 0;
  logic [7:0] fill = '0;
  bit         done_exp = 0;
  int         busy_seen = 0;
  rsp_t       rq[$];
  rsp_t       hq[$];
  rsp_t       re;
  rsp_t       he;

  function automatic logic [7:0] view(input int a);
    if (a >= CELLS) return 8'h00;
    if (clr_act && a < clr_cnt) return fill;
    return scr[a];
  endfunction

  // Monitor: pops expected responses whenever the DUT presents one
  always @(negedge pixel_clock) begin
    while (rq.size() > 0 && rq[0].due < cyc) begin
      chk("render_missing", 0, 1);
      void'(rq.pop_front());
    end
    while (hq.size() > 0 && hq[0].due < cyc) begin
      chk("host_missing", 0, 1);
      void'(hq.pop_front());
    end
    if (render_valid) begin
      if (rq.size() == 0) chk("render_extra", 1, 0);
      else begin
        re = rq.pop_front();
        chk("render_data", int'(render_data), int'(re.val));
        chk("render_latency", cyc, re.due);
      end
    end else begin
      chk("render_data_idle", int'(render_data), 0);
    end
    if (host_rvalid) begin
      if (hq.size() == 0) chk("host_extra", 1, 0);
      else begin
        he = hq.pop_front();
        chk("host_rdata", int'(host_rdata), int'(he.val));
        chk("host_latency", cyc, he.due);
      end
    end else begin
      chk("host_rdata_idle", int'(host_rdata), 0);
    end
  end

  // One clock of stimulus; checks the combinational grant and updates the model
  task automatic step(input logic rr, input logic [11:0] ri,
                      input logic hv, input logic hwe,
                      input logic [11:0] ha, input logic [7:0] hd,
                      input logic cs, input logic [7:0] cc,
                      output logic acc);
    bit         erdy, een, ewe, was;
    int         ea, ew, rix, hax;
    rsp_t       e;
    @(negedge pixel_clock);
    render_req   = rr;
    render_index = ri;
    host_valid   = hv;
    host_we      = hwe;
    host_addr    = ha;
    host_wdata   = hd;
    clear_start  = cs;
    clear_char   = cc;
    #1;
    rix  = int'(ri);
    hax  = int'(ha);
    was  = clr_act;
    erdy = hv && !rr && !clr_act;
    een = 0; ewe = 0; ea = 0; ew = 0;
    if (rr) begin
      een = rix < CELLS; ea = rix;
    end else if (clr_act) begin
      een = 1; ewe = 1; ea = clr_cnt; ew = int'(fill);
    end else if (erdy) begin
      een = hax < CELLS; ewe = hwe && een; ea = hax; ew = int'(hd);
    end
    chk("host_ready", int'(host_ready), int'(erdy));
    chk("mem_en", int'(mem_en), int'(een));
    if (een) begin
      chk("mem_addr", int'(mem_addr), ea);
      chk("mem_we", int'(mem_we), int'(ewe));
      if (ewe) chk("mem_wdata", int'(mem_wdata), ew);
    end else begin
      chk("mem_we_idle", int'(mem_we), 0);
      chk("mem_wdata_idle", int'(mem_wdata), 0);
    end
    chk("clear_busy", int'(clear_busy), int'(clr_act));
    chk("clear_done", int'(clear_done), int'(done_exp));
    if (clear_busy) busy_seen++;
    done_exp = 0;
    acc = erdy;
    if (rr) begin
      e.due = cyc + 1; e.val = view(rix); rq.push_back(e);
    end
    if (erdy) begin
      if (hwe) begin
        if (hax < CELLS) scr[hax] = hd;
      end else begin
        e.due = cyc + 1; e.val = view(hax); hq.push_back(e);
      end
    end
    if (was && !rr) begin
      clr_cnt++;
      if (clr_cnt == CELLS) begin
        for (int i = 0; i < CELLS; i++) scr[i] = fill;
        clr_act = 0;
        done_exp = 1;
      end
    end else if (!was && cs) begin
      clr_act = 1; clr_cnt = 0; fill = cc;
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic do_reset(input int n);
    @(negedge pixel_clock);
    reset = 1'b0;
    render_req = 0; host_valid = 0; host_we = 0;
    clear_start = 0; render_index = 0; host_addr = 0;
    repeat (n) @(negedge pixel_clock);
    #1;
    chk("rst_render_valid", int'(render_valid), 0);
    chk("rst_render_data", int'(render_data), 0);
    chk("rst_host_rvalid", int'(host_rvalid), 0);
    chk("rst_host_rdata", int'(host_rdata), 0);
    chk("rst_clear_busy", int'(clear_busy), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    chk("rst_host_ready", int'(host_ready), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    if (clr_act)
      for (int i = 0; i < clr_cnt; i++) scr[i] = fill;
    clr_act = 0;
    done_exp = 0;
    reset = 1'b1;
  endtask

  task automatic check_cover(input string nm);
    int bad = 0;
    for (int a = 0; a < 4096; a++)
      if (a < CELLS ? wr_cnt[a] != 1 : wr_cnt[a] != 0) bad++;
    chk(nm, bad, 0);
  endtask

  logic        acc;
  logic        rr, cs, h_v, h_we;
  logic [11:0] ri, h_a;
  logic [7:0]  h_d;
  int          stalls, g;

  initial begin
    for (int i = 0; i < CELLS; i++) scr[i] = 8'h00;

    // reset and idle
    do_reset(2);
    idle(2);

    // host write then read
    step(0, 0, 1, 1, 12'd5, 8'h41, 0, 0, acc);
    step(0, 0, 1, 0, 12'd5, 8'h00, 0, 0, acc);
    idle(2);

    // render wins over host, host follows next cycle
    step(1, 12'd5, 1, 0, 12'd5, 8'h00, 0, 0, acc);
    step(0, 0, 1, 0, 12'd5, 8'h00, 0, 0, acc);
    idle(2);

    // full clear, host read held throughout, served on start cycle
    cnt_clr = 1; idle(1); cnt_clr = 0; cnt_en = 1;
    busy_seen = 0;
    step(0, 0, 1, 0, 12'd5, 8'h00, 1, 8'h20, acc);
    g = 0;
    while (clr_act && g < 3000) begin
      step(0, 0, 1, 0, 12'd5, 8'h00, 0, 0, acc); g++;
    end
    step(0, 0, 1, 0, 12'd5, 8'h00, 0, 0, acc);
    idle(2);
    cnt_en = 0;
    chk("clear_cycles", busy_seen, CELLS);
    check_cover("clear_coverage");

    // clear with a render every 8th cycle and an ignored restart
    cnt_clr = 1; idle(1); cnt_clr = 0; cnt_en = 1;
    busy_seen = 0; stalls = 0;
    step(0, 0, 0, 0, 0, 0, 1, 8'h2E, acc);
    g = 0;
    while (clr_act && g < 6000) begin
      rr = (g % 8 == 7);
      ri = 12'($urandom_range(0, CELLS - 1));
      if (rr) stalls++;
      step(rr, ri, 1, 0, 12'd100, 0, (g == 500), 8'h55, acc);
      g++;
    end
    step(0, 0, 1, 0, 12'd100, 0, 0, 0, acc);
    idle(2);
    cnt_en = 0;
    chk("clear_stall_cycles", busy_seen, CELLS + stalls);
    check_cover("clear_stall_coverage");

    // out-of-range host write/read and render
    step(0, 0, 1, 1, 12'd2400, 8'h99, 0, 0, acc);
    step(1, 12'd4095, 0, 0, 0, 0, 0, 0, acc);
    step(0, 0, 1, 0, 12'd2400, 0, 0, 0, acc);
    step(1, 12'd2399, 0, 0, 0, 0, 0, 0, acc);
    idle(2);

    // reset at clear pointer 1000 aborts without clear_done
    step(0, 0, 0, 0, 0, 0, 1, 8'h3C, acc);
    while (clr_act && clr_cnt < 1000)
      step(0, 0, 0, 0, 0, 0, 0, 0, acc);
    do_reset(1);
    idle(4);
    step(0, 0, 1, 1, 12'd1000, 8'h77, 0, 0, acc);
    step(1, 12'd999, 0, 0, 0, 0, 0, 0, acc);
    step(1, 12'd1001, 0, 0, 0, 0, 0, 0, acc);
    step(1, 12'd1000, 0, 0, 0, 0, 0, 0, acc);
    idle(2);

    // randomized mix of all three clients
    h_v = 0; h_we = 0; h_a = 0; h_d = 0;
    for (int i = 0; i < 900; i++) begin
      rr = ($urandom % 3) == 0;
      ri = (($urandom % 8) == 0) ? 12'($urandom_range(2400, 4095))
                                 : 12'($urandom_range(0, 2399));
      if (!h_v && ($urandom % 2) == 1) begin
        h_v = 1;
        h_we = 1'($urandom % 2);
        h_a = (($urandom % 10) == 0) ? 12'($urandom_range(2400, 4095))
                                     : 12'($urandom_range(0, 2399));
        h_d = 8'($urandom);
      end
      cs = ($urandom % 300) == 0;
      step(rr, ri, h_v, h_we, h_a, h_d, cs, 8'($urandom), acc);
      if (acc) h_v = 0;
    end
    g = 0;
    while ((clr_act || h_v) && g < 5000) begin
      step(0, 0, h_v, h_we, h_a, h_d, 0, 0, acc);
      if (acc) h_v = 0;
      g++;
    end
    idle(4);
    chk("render_queue_empty", rq.size(), 0);
    chk("host_queue_empty", hq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/text_buffer_arbiter.md
Name: text_buffer_arbiter

Overview:
- Owns the single-port, synchronous-read text RAM that holds the 80x30 character screen.
- Shares the RAM between three clients:
  - the character renderer, which fetches one character code per glyph cell;
  - a host port, for CPU/UART character reads and writes;
  - an internal clear-screen sequencer, which fills every cell with one character.
- Sits between the renderer's char_index/char_data path and the RAM. The renderer always has priority so that video is never starved.

Parameters:
COLS, 80, text columns per row
ROWS, 30, text rows
ADDR_WIDTH, 12, cell address width; must satisfy 2^ADDR_WIDTH >= COLS*ROWS
CELLS, COLS*ROWS (2400), number of valid cells (derived, do not override)

Ports:
pixel_clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-low reset
render_req  input  1  renderer fetch strobe, one cycle per fetch
render_index  input  ADDR_WIDTH  cell to fetch
render_data  output  8  fetched character code
render_valid  output  1  render_data valid; exactly 1 cycle after render_req
host_valid  input  1  host request pending
host_ready  output  1  host request accepted this cycle
host_we  input  1  1 = write, 0 = read
host_addr  input  ADDR_WIDTH  host cell address
host_wdata  input  8  host write data
host_rdata  output  8  host read data
host_rvalid  output  1  host_rdata valid; 1 cycle after read acceptance
clear_start  input  1  start clear-screen sequence
clear_char  input  8  fill character, sampled on accepted clear_start
clear_busy  output  1  clear sequence in progress
clear_done  output  1  one-cycle pulse after the last cell is written
mem_en  output  1  RAM enable
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  8  RAM write data
mem_rdata  input  8  RAM read data, valid the cycle after a read with mem_en=1

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; clear pointer and latched fill char go to 0.
  - render_valid, host_rvalid, clear_busy and clear_done go to 0.
  - render_data and host_rdata read 0x00.
  - A clear in progress is aborted with no clear_done pulse; any pending read response is dropped.
- Grant priority each cycle, evaluated combinationally: render > clear > host. Exactly one client owns the mem_* outputs in a cycle.
- Render grant:
  - Condition: render_req=1.
  - Drives mem_en=1, mem_we=0, mem_addr=render_index.
  - Next cycle: render_valid=1, and render_data = mem_rdata.
  - If render_index >= CELLS: no RAM access (mem_en=0), render_valid still pulses, render_data=0x00.
- FSM states:
  - IDLE:
    - clear_start=1 latches clear_char, sets the pointer to 0 and moves to CLEAR.
    - The start cycle itself performs no clear write.
    - clear_start in the same cycle as a host request: the host request is still served that cycle.
  - CLEAR:
    - clear_busy=1.
    - Each cycle with render_req=0: mem_en=1, mem_we=1, mem_addr=pointer, mem_wdata=fill char, then pointer increments.
    - Cycles with render_req=1 stall the pointer.
    - After writing pointer CELLS-1: move to IDLE, clear_busy drops, clear_done=1 for exactly one cycle.
    - clear_start while in CLEAR is ignored; no restart, and clear_char is not resampled.
- Host port:
  - host_ready = host_valid & ~render_req & (state==IDLE). It is combinational and never asserts in CLEAR.
  - A transfer occurs when host_valid & host_ready. The host must hold addr, we and wdata until accepted.
  - Write: mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata. If host_addr >= CELLS the write is dropped (mem_en=0) but the handshake still completes.
  - Read: host_rvalid=1 on the next cycle, with host_rdata=mem_rdata, or 0x00 if host_addr >= CELLS.
- Response tracking: two registered flags (render read, host read) plus registered out-of-range bits steer mem_rdata. A response is never delivered to both clients.
- Outputs when not valid:
  - render_data and host_rdata are 0x00 when their valid flag is 0.
  - mem_we and mem_wdata are 0 whenever mem_en=0.
- Clear duration: total clear time = CELLS + (number of render_req cycles during CLEAR) cycles.

Test Plan:
1. Reset then idle:
   - Stimulus: reset=0 for 2 cycles, then release.
   - Required: every output 0; mem_en=0 with no requests.
2. Host write/read:
   - Stimulus: write 0x41 to addr 5; read addr 5.
   - Required: host_ready=1 on each request; host_rvalid one cycle after the read with host_rdata=0x41.
3. Render priority:
   - Stimulus: render_req=1 (index 5) and host_valid=1 in the same cycle.
   - Required: host_ready=0 that cycle; render_valid next cycle with 0x41; host accepted the following cycle.
4. Clear sequence:
   - Stimulus: clear_start with clear_char=0x20, no render traffic.
   - Required: exactly 2400 writes to addresses 0..2399; clear_done pulses on the cycle after the last write; host_ready=0 throughout.
5. Clear with render interference:
   - Stimulus: render_req every 8th cycle during clear.
   - Required: every render fetch is served; clear finishes in 2400 + (stall count) cycles; no address is skipped or written twice.
6. Boundaries:
   - host write to addr 2400 -> no RAM write, handshake completes.
   - render_index 4095 -> render_data=0x00.
   - reset asserted mid-clear at pointer 1000 -> IDLE, no clear_done.
   - clear_start during CLEAR -> ignored.
